// File: rtl/cntr_updn_mod_nb.sv
// cntr_updn_mod_nb: n-bit up/down counter, runtime modulus, load, wrap/saturate, rco and tc
// Optional prescaler on the count enable when CNTR_PRESCALE_EN is defined.
module cntr_updn_mod_nb #(
  parameter int n = 8,
  parameter bit SAT = 1'b0,
  parameter int PS_DIV = 4
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         ld,
  input  logic [n-1:0] D,
  input  logic         en,
  input  logic         dir,
  input  logic [n-1:0] max,
  output logic [n-1:0] count,
  output logic         rco,
  output logic         tc
);
  logic tick, step, term;
  logic [n-1:0] nxt;
`ifdef CNTR_PRESCALE_EN
  localparam int PW = PS_DIV > 1 ? $clog2(PS_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PS_DIV - 1);
  logic [PW-1:0] ps;
  assign tick = ps == PS_LAST;
  always_ff @(posedge clk or posedge clr)
    if (clr) ps <= '0;
    else if (ld) ps <= '0;
    else if (en) ps <= tick ? '0 : ps + 1'b1;
`else
  // PS_DIV is always >= 1, so this is a constant 1
  assign tick = PS_DIV >= 1;
`endif
  assign step = en & tick;
  assign term = dir ? count >= max : count == '0;
  assign rco = step & term;
  // Terminal goes to 0 when wrapping up or saturating down, otherwise to max
  always_comb nxt = term ? ((dir ^ SAT) ? '0 : max) : dir ? count + 1'b1 : count > max ? max : count - 1'b1;
  always_ff @(posedge clk or posedge clr)
    if (clr) begin
      count <= '0;
      tc <= 1'b0;
    end else if (ld) begin
      count <= D > max ? max : D;
      tc <= 1'b0;
    end else begin
      if (step) count <= nxt;
      tc <= rco;
    end
endmodule
